// File: rtl/kb_code_sequencer_if.sv
// Keyboard code sequencer bus: scan byte input, lookup side-channel,
// character FIFO read port and status.
interface kb_code_sequencer_if;
  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic [7:0] lut_key_code;
  logic [7:0] lut_ascii_code;
  logic       rd_char;
  logic [7:0] char_out;
  logic       char_empty;
  logic       char_full;
  logic       shift_active;
  logic [7:0] drop_count;

  // Sequencer side
  modport slave (
    input  scan_done_tick, scan_code, lut_ascii_code, rd_char,
    output lut_key_code, char_out, char_empty, char_full, shift_active, drop_count
  );

  // Environment side: PS/2 receiver, lookup ROM, character consumer
  modport master (
    output scan_done_tick, scan_code, lut_ascii_code, rd_char,
    input  lut_key_code, char_out, char_empty, char_full, shift_active, drop_count
  );
endinterface

// File: rtl/kb_code_sequencer.sv
// PS/2 scan-code sequencer: decodes break/extended prefixes and shift,
// runs each make code through the registered scan-to-ASCII lookup, fixes
// letter case and queues characters in a small show-ahead FIFO.
module kb_code_sequencer #(
  parameter int         FIFO_AW    = 2,
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0
) (
  input logic             clk,
  input logic             reset,
  kb_code_sequencer_if.slave kb
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, BRK, LOOK, WRITE} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } skid_t;

  state_t     state_q, state_d;
  skid_t      skid_q, skid_d;
  logic       ext_q, ext_d;
  logic       shift_q, shift_d;
  logic [7:0] key_q, key_d;
  logic [7:0] drop_q, drop_d;

  logic       src_vld;
  logic [7:0] src;
  logic       src_is_shift;
  logic       push, pop, fifo_drop, skid_ovf;
  logic [7:0] wr_char;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         hold_q;
  logic               empty, full;

  assign empty = (count == '0);
  assign full  = (count == (FIFO_AW+1)'(DEPTH));
  // A pop on an empty FIFO is simply ignored
  assign pop   = kb.rd_char & ~empty;

  // Next-state, byte decode, skid management and write-side decisions
  always_comb begin
    state_d   = state_q;
    skid_d    = skid_q;
    ext_d     = ext_q;
    shift_d   = shift_q;
    key_d     = key_q;
    push      = 1'b0;
    fifo_drop = 1'b0;
    skid_ovf  = 1'b0;
    src_vld   = 1'b0;
    src       = kb.scan_code;
    wr_char   = kb.lut_ascii_code;

    // Byte source: skid wins; a live tick that loses to it refills the skid.
    // While a lookup is in flight, ticks land in the skid, overwriting any
    // byte already parked there.
    if (state_q == IDLE || state_q == BRK) begin
      if (skid_q.vld) begin
        src_vld    = 1'b1;
        src        = skid_q.data;
        skid_d.vld = kb.scan_done_tick;
        if (kb.scan_done_tick) skid_d.data = kb.scan_code;
      end else if (kb.scan_done_tick) begin
        src_vld = 1'b1;
      end
    end else if (kb.scan_done_tick) begin
      skid_ovf = skid_q.vld;
      skid_d   = '{vld: 1'b1, data: kb.scan_code};
    end

    src_is_shift = (src == 8'h12) || (src == 8'h59);

    case (state_q)
      IDLE: begin
        if (src_vld) begin
          if (src == BREAK_CODE) begin
            state_d = BRK;
          end else if (src == EXT_CODE) begin
            ext_d = 1'b1;
          end else if (src_is_shift) begin
            shift_d = 1'b1;
            ext_d   = 1'b0;
          end else if (ext_q) begin
            // extended keys have no character: swallow the code
            ext_d = 1'b0;
          end else begin
            key_d   = src;
            state_d = LOOK;
          end
        end
      end
      BRK: begin
        // byte after F0 is a release; only shift releases matter
        if (src_vld) begin
          if (src_is_shift) shift_d = 1'b0;
          ext_d   = 1'b0;
          state_d = IDLE;
        end
      end
      LOOK: state_d = WRITE;
      WRITE: begin
        if (kb.lut_ascii_code >= 8'h41 && kb.lut_ascii_code <= 8'h5A && !shift_q)
          wr_char = kb.lut_ascii_code + 8'h20;
        // full is fine if the consumer frees a slot on this same edge
        if (!full || kb.rd_char) push = 1'b1;
        else                     fifo_drop = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lost-byte counter: up to two losses per cycle, clamps at FF
  always_comb begin
    logic [8:0] sum;
    sum    = {1'b0, drop_q} + 9'(skid_ovf) + 9'(fifo_drop);
    drop_d = sum[8] ? 8'hFF : sum[7:0];
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      skid_q  <= '0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
      key_q   <= 8'h00;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      ext_q   <= ext_d;
      shift_q <= shift_d;
      key_q   <= key_d;
      drop_q  <= drop_d;
    end
  end

  // FIFO storage; stale entries are harmless since pointers gate reads
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_char;
  end

  // FIFO pointers, occupancy and last-popped head for the empty case
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
        hold_q <= mem[rd_ptr];
      end
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  assign kb.lut_key_code = key_q;
  assign kb.char_out     = empty ? hold_q : mem[rd_ptr];
  assign kb.char_empty   = empty;
  assign kb.char_full    = full;
  assign kb.shift_active = shift_q;
  assign kb.drop_count   = drop_q;

endmodule

// File: tb/tb_kb_code_sequencer.sv
// Bench for kb_code_sequencer: directed scenarios plus a random scan-byte
// stream checked against a prefix/shift decoder model.
module tb_kb_code_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  kb_code_sequencer_if kif();

  kb_code_sequencer #(.FIFO_AW(2), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
    .clk  (clk),
    .reset(reset),
    .kb   (kif)
  );

  always #5 clk = ~clk;

  // Scan-to-ASCII table (subset of set 2)
  function automatic logic [7:0] lut_fn(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h41;  8'h32: return 8'h42;
      8'h21: return 8'h43;  8'h23: return 8'h44;
      8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;
      8'h2E: return 8'h35;  8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      default: return 8'h2A;
    endcase
  endfunction

  // Registered lookup ROM
  always @(posedge clk) kif.lut_ascii_code <= lut_fn(kif.lut_key_code);

  function automatic logic [7:0] exp_char(input logic [7:0] c, input bit sh);
    logic [7:0] v;
    v = lut_fn(c);
    if (!sh && v >= 8'h41 && v <= 8'h5A) v = v + 8'h20;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; kif.scan_done_tick = 1'b0; kif.scan_code = 8'h00; kif.rd_char = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk); kif.scan_done_tick = 1'b1; kif.scan_code = b;
    @(negedge clk); kif.scan_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b); idle(3);
  endtask

  task automatic pop();
    @(negedge clk); kif.rd_char = 1'b1;
    @(negedge clk); kif.rd_char = 1'b0;
  endtask

  task automatic tick3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk); kif.scan_done_tick = 1'b1; kif.scan_code = a;
    @(negedge clk); kif.scan_code = b;
    @(negedge clk); kif.scan_code = c;
    @(negedge clk); kif.scan_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (kif.lut_key_code !== 8'h00) begin nerr++; $display("FAIL reset_key got %h want 00", kif.lut_key_code); end
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got %b want 1", kif.char_empty); end
    nvec++; if (kif.char_full !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", kif.char_full); end
    nvec++; if (kif.char_out !== 8'h00) begin nerr++; $display("FAIL reset_char got %h want 00", kif.char_out); end
    nvec++; if (kif.shift_active !== 1'b0) begin nerr++; $display("FAIL reset_shift got %b want 0", kif.shift_active); end
    nvec++; if (kif.drop_count !== 8'h00) begin nerr++; $display("FAIL reset_drop got %h want 00", kif.drop_count); end
  endtask

  task automatic test_basic();
    pulse(8'h1C);
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL lat_edge1 empty got %b want 1", kif.char_empty); end
    idle(1);
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL lat_edge2 empty got %b want 1", kif.char_empty); end
    idle(1);
    nvec++; if (kif.char_empty !== 1'b0) begin nerr++; $display("FAIL lat_edge3 empty got %b want 0", kif.char_empty); end
    nvec++; if (kif.char_out !== 8'h61) begin nerr++; $display("FAIL basic_char got %h want 61", kif.char_out); end
    pop();
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL basic_pop empty got %b want 1", kif.char_empty); end
  endtask

  task automatic test_shift();
    send(8'h12);
    nvec++; if (kif.shift_active !== 1'b1) begin nerr++; $display("FAIL shift_press got %b want 1", kif.shift_active); end
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    nvec++; if (kif.shift_active !== 1'b0) begin nerr++; $display("FAIL shift_release got %b want 0", kif.shift_active); end
    nvec++; if (kif.char_out !== 8'h41) begin nerr++; $display("FAIL shift_upper got %h want 41", kif.char_out); end
    pop();
    nvec++; if (kif.char_out !== 8'h61 || kif.char_empty !== 1'b0) begin nerr++; $display("FAIL shift_lower got %h/%b want 61/0", kif.char_out, kif.char_empty); end
    pop();
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL shift_count empty got %b want 1", kif.char_empty); end
  endtask

  task automatic test_ext();
    send(8'hE0); send(8'h75);
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL ext_discard empty got %b want 1", kif.char_empty); end
    send(8'h16);
    nvec++; if (kif.char_empty !== 1'b0 || kif.char_out !== 8'h31) begin nerr++; $display("FAIL ext_cleared got %h/%b want 31/0", kif.char_out, kif.char_empty); end
    pop();
  endtask

  task automatic test_full();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 4; i++) send(codes[i]);
    nvec++; if (kif.char_full !== 1'b1) begin nerr++; $display("FAIL full_flag got %b want 1", kif.char_full); end
    send(codes[4]);
    nvec++; if (kif.drop_count !== 8'h01) begin nerr++; $display("FAIL full_drop got %h want 01", kif.drop_count); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (kif.char_out !== 8'(8'h31 + i)) begin nerr++; $display("FAIL full_order[%0d] got %h want %h", i, kif.char_out, 8'(8'h31 + i)); end
      pop();
    end
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL full_drained empty got %b want 1", kif.char_empty); end
    // fifth push rescued by a pop in the write cycle
    do_reset();
    for (int i = 0; i < 4; i++) send(codes[i]);
    pulse(codes[4]); idle(1);
    kif.rd_char = 1'b1; @(negedge clk); kif.rd_char = 1'b0;
    nvec++; if (kif.drop_count !== 8'h00 || kif.char_full !== 1'b1) begin nerr++; $display("FAIL full_rescue drop/full got %h/%b want 00/1", kif.drop_count, kif.char_full); end
    for (int i = 1; i < 5; i++) begin
      nvec++; if (kif.char_out !== 8'(8'h31 + i)) begin nerr++; $display("FAIL rescue_order[%0d] got %h want %h", i, kif.char_out, 8'(8'h31 + i)); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick3(8'h16, 8'h1E, 8'h26);
    idle(8);
    nvec++; if (kif.drop_count !== 8'h01) begin nerr++; $display("FAIL b2b_drop got %h want 01", kif.drop_count); end
    nvec++; if (kif.char_out !== 8'h31) begin nerr++; $display("FAIL b2b_first got %h want 31", kif.char_out); end
    pop();
    nvec++; if (kif.char_out !== 8'h33 || kif.char_empty !== 1'b0) begin nerr++; $display("FAIL b2b_second got %h/%b want 33/0", kif.char_out, kif.char_empty); end
    pop();
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL b2b_count empty got %b want 1", kif.char_empty); end
  endtask

  task automatic test_double_drop();
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    tick3(8'h1C, 8'h32, 8'h21);
    nvec++; if (kif.drop_count !== 8'h02) begin nerr++; $display("FAIL dbl_drop got %h want 02", kif.drop_count); end
    idle(8);
    nvec++; if (kif.drop_count !== 8'h03) begin nerr++; $display("FAIL dbl_drop_skid got %h want 03", kif.drop_count); end
  endtask

  task automatic test_reset_look();
    do_reset();
    send(8'h12);
    tick3(8'h16, 8'h1E, 8'h26);
    idle(8);
    pulse(8'h1C);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    nvec++; if (kif.lut_key_code !== 8'h00 || kif.char_out !== 8'h00) begin nerr++; $display("FAIL rlook_key_char got %h/%h want 00/00", kif.lut_key_code, kif.char_out); end
    nvec++; if (kif.char_empty !== 1'b1 || kif.char_full !== 1'b0) begin nerr++; $display("FAIL rlook_flags got %b/%b want 1/0", kif.char_empty, kif.char_full); end
    nvec++; if (kif.shift_active !== 1'b0 || kif.drop_count !== 8'h00) begin nerr++; $display("FAIL rlook_shift_drop got %b/%h want 0/00", kif.shift_active, kif.drop_count); end
    idle(4);
    nvec++; if (kif.char_empty !== 1'b1) begin nerr++; $display("FAIL rlook_nopush empty got %b want 1", kif.char_empty); end
  endtask

  task automatic test_saturate();
    logic [7:0] prev;
    bit mono;
    mono = 1'b1;
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    prev = kif.drop_count;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); kif.scan_done_tick = 1'b1; kif.scan_code = 8'h16;
      if (kif.drop_count < prev) mono = 1'b0;
      prev = kif.drop_count;
    end
    @(negedge clk); kif.scan_done_tick = 1'b0;
    idle(8);
    nvec++; if (kif.drop_count !== 8'hFF) begin nerr++; $display("FAIL sat_value got %h want FF", kif.drop_count); end
    nvec++; if (mono !== 1'b1) begin nerr++; $display("FAIL sat_nowrap got %b want 1", mono); end
  endtask

  task automatic test_random();
    logic [7:0] pool [16];
    logic [7:0] q [$];
    logic [7:0] b;
    bit brk, ext, sh;
    pool = '{8'h12, 8'h59, 8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h21, 8'h23,
             8'h16, 8'h1E, 8'h26, 8'h25, 8'h29, 8'h5A, 8'h75, 8'h2E};
    brk = 0; ext = 0; sh = 0;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      b = pool[$urandom_range(0, 15)];
      send(b);
      if (brk) begin
        if (b == 8'h12 || b == 8'h59) sh = 0;
        ext = 0; brk = 0;
      end else if (b == 8'hF0) brk = 1;
      else if (b == 8'hE0) ext = 1;
      else if (b == 8'h12 || b == 8'h59) begin sh = 1; ext = 0; end
      else if (ext) ext = 0;
      else q.push_back(exp_char(b, sh));
      nvec++;
      if (kif.char_empty !== (q.size() == 0)) begin
        nerr++; $display("FAIL rand_empty[%0d] byte %h got %b want %b", i, b, kif.char_empty, q.size() == 0);
        q.delete();
        for (int k = 0; k < 4; k++) if (kif.char_empty === 1'b0) pop();
      end else if (q.size() != 0) begin
        nvec++; if (kif.char_out !== q[0]) begin nerr++; $display("FAIL rand_char[%0d] byte %h got %h want %h", i, b, kif.char_out, q[0]); end
        void'(q.pop_front());
        pop();
      end
    end
    nvec++; if (kif.shift_active !== sh) begin nerr++; $display("FAIL rand_shift got %b want %b", kif.shift_active, sh); end
    nvec++; if (kif.drop_count !== 8'h00) begin nerr++; $display("FAIL rand_drop got %h want 00", kif.drop_count); end
  endtask

  initial begin
    reset = 1'b1;
    kif.scan_done_tick = 1'b0; kif.scan_code = 8'h00; kif.rd_char = 1'b0;
    test_reset();
    test_basic();
    test_shift();
    test_ext();
    test_full();
    test_back_to_back();
    test_double_drop();
    test_reset_look();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
